// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule sizes, expander state encoding,
// round-constant lookup and the forward S-box table.
package aes_pkg;

  localparam int NK            = 8;
  localparam int NUM_EXP_WORDS = 60;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  // Packed with an ascending range so SBOX[x] picks the x-th byte listed.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // AES-256 only ever needs Rcon[1..7].
  function automatic logic [7:0] rcon(input logic [2:0] r);
    case (r)
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes256_key_expander_sbox.sv
// Combinational forward S-box lookup, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/aes256_key_expander.sv
// AES-256 key expander: loads 8 key words, then streams w0..w59 from a
// sliding 8-word window with one S-box stage per output word.
module aes256_key_expander
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_keyEnable,
  input  logic [31:0] i_key,
  input  logic        i_expandedKeyReady,
  output logic        o_expandedKeyEnable,
  output logic [31:0] o_expandedKey,
  output logic        o_keyDone,
  output logic        o_busy,
  output state_t      o_state
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_EXP_WORDS - 1);
  localparam logic [2:0] LAST_KEY = 3'(NK - 1);

  // Output handshake: a word moves on every cycle where o_expandedKeyEnable
  // and i_expandedKeyReady are both high; while ready is low the word,
  // index and window hold and enable stays high.
  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_count;
  logic [5:0]  r_idx;
  logic [31:0] r_win [NK];
  logic        r_en;
  logic        r_done;
  logic [31:0] r_key;

  logic        w_key_take;
  logic        w_last_key;
  logic        w_xfer;
  logic [5:0]  w_next_idx;
  logic [2:0]  w_phase;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_older;
  logic [31:0] w_next_word;

  assign w_key_take = i_keyEnable && (r_state == IDLE || r_state == LOAD);
  assign w_last_key = i_keyEnable && (r_state == LOAD) && (r_count == LAST_KEY);
  assign w_xfer     = r_en && i_expandedKeyReady;
  assign w_next_idx = r_idx + 6'd1;
  assign w_phase    = w_next_idx[2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (i_keyEnable) w_next_state = LOAD;
      LOAD:    if (w_last_key) w_next_state = EMIT;
      EMIT:    if (w_xfer && r_idx == LAST_IDX) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // RotWord only on the first word of each 8-word group.
  assign w_sub_in = (w_phase == 3'd0) ? {r_key[23:0], r_key[31:24]} : r_key;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .i_in  (w_sub_in[8*g +: 8]),
      .o_out (w_sub_out[8*g +: 8])
    );
  end

  always_comb begin
    w_temp = r_key;
    if (w_phase == 3'd0)      w_temp = w_sub_out ^ {rcon(w_next_idx[5:3]), 24'h0};
    else if (w_phase == 3'd4) w_temp = w_sub_out;
  end

  // The window only starts sliding once w8 is sent, so w(i-7) sits in slot 0
  // when leaving w7 and in slot 1 afterwards.
  assign w_older     = (r_idx == 6'd7) ? r_win[0] : r_win[1];
  assign w_next_word = (w_next_idx < 6'd8) ? r_win[w_next_idx[2:0]] : (w_older ^ w_temp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_key   <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < NK; k++) r_win[k] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_key_take) begin
        r_win[r_count] <= i_key;
        r_count        <= r_count + 3'd1;
      end
      if (w_last_key) begin
        r_en  <= 1'b1;
        r_key <= r_win[0];
        r_idx <= '0;
      end else if (w_xfer) begin
        if (r_idx == LAST_IDX) begin
          r_en   <= 1'b0;
          r_key  <= '0;
          r_idx  <= '0;
          r_done <= 1'b1;
        end else begin
          r_idx <= w_next_idx;
          r_key <= w_next_word;
          if (r_idx >= 6'd8) begin
            for (int k = 0; k < NK - 1; k++) r_win[k] <= r_win[k+1];
            r_win[NK-1] <= r_key;
          end
        end
      end
    end
  end

  assign o_expandedKeyEnable = r_en;
  assign o_expandedKey       = r_key;
  assign o_keyDone           = r_done;
  assign o_busy              = (r_state == LOAD) || (r_state == EMIT);
  assign o_state             = r_state;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Bench for aes256_key_expander: directed key loads, an array-based reference
// schedule with its own derived S-box, and a queue scoreboard on the word stream.
module tb_aes256_key_expander;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_en = 1'b0;
  logic [31:0] key_w = '0;
  logic        ready = 1'b1;
  logic        o_en;
  logic [31:0] o_key;
  logic        o_done;
  logic        o_busy;
  state_t      o_state;

  aes256_key_expander dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_keyEnable         (key_en),
    .i_key               (key_w),
    .i_expandedKeyReady  (ready),
    .o_expandedKeyEnable (o_en),
    .o_expandedKey       (o_key),
    .o_keyDone           (o_done),
    .o_busy              (o_busy),
    .o_state             (o_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] anchor[int];
  logic [31:0] cur_key [8];
  logic [31:0] model_w [60];
  logic [7:0]  sbox_m [256];
  int  n_checks = 0;
  int  n_pass = 0;
  int  run_xfer, en_cycles, first_en_cyc, last_xfer_cyc, last_key_cyc;
  bit  run_done;
  bit  expect_full_en;
  bit  hold_pending;
  logic [31:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] b, inv;
    for (int v = 0; v < 256; v++) begin
      b   = 8'(v);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, b);
      sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  task automatic build_model();
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) model_w[i] = cur_key[i];
    for (int i = 8; i < 60; i++) begin
      t = model_w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      model_w[i] = model_w[i-8] ^ t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_a3_key();
    cur_key[0] = 32'h603deb10; cur_key[1] = 32'h15ca71be;
    cur_key[2] = 32'h2b73aef0; cur_key[3] = 32'h857d7781;
    cur_key[4] = 32'h1f352c07; cur_key[5] = 32'h3b6108d7;
    cur_key[6] = 32'h2d9810a3; cur_key[7] = 32'h0914dff4;
    anchor.delete();
    for (int i = 0; i < 8; i++) anchor[i] = cur_key[i];
    anchor[8]  = 32'h9ba35411; anchor[9]  = 32'h8e6925af;
    anchor[10] = 32'ha51a8b5f; anchor[11] = 32'h2067fcde;
    anchor[12] = 32'ha8b09c1a; anchor[59] = 32'h706c631e;
  endtask

  task automatic start_run(input bit full_en);
    build_model();
    exp_q.delete();
    for (int i = 0; i < 60; i++) exp_q.push_back(model_w[i]);
    run_xfer = 0; en_cycles = 0; run_done = 0; hold_pending = 0;
    first_en_cyc = -1; last_xfer_cyc = -1;
    expect_full_en = full_en;
  endtask

  task automatic load_key(input int gap);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      key_en = 1'b1;
      key_w  = cur_key[i];
      if (i == 7) last_key_cyc = cyc;
      if (gap > 0 && i < 7) begin
        @(posedge clk); #1;
        key_en = 1'b0;
        key_w  = 32'hdeadbeef;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    key_en = 1'b0;
    key_w  = '0;
  endtask

  task automatic wait_done(input int bound);
    for (int t = 0; t < bound && !run_done; t++) @(posedge clk);
    #1;
    check("keydone_seen", 32'(run_done), 32'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (hold_pending) begin
          check("hold_value", o_key, hold_val);
          check("hold_enable", 32'(o_en), 32'd1);
          hold_pending = 0;
        end
        if (o_en) begin
          if (en_cycles == 0) begin
            first_en_cyc = cyc;
            check("busy_in_emit", 32'(o_busy), 32'd1);
          end
          en_cycles++;
          if (!ready) begin
            hold_pending = 1;
            hold_val     = o_key;
          end else begin
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL extra_word: got %h, no word expected", o_key);
            end else begin
              exp = exp_q.pop_front();
              check($sformatf("w%0d", run_xfer), o_key, exp);
            end
            if (anchor.exists(run_xfer)) check($sformatf("anchor_w%0d", run_xfer), o_key, anchor[run_xfer]);
            run_xfer++;
            last_xfer_cyc = cyc;
          end
        end
        if (o_done) begin
          check("words_before_done", 32'(run_xfer), 32'd60);
          check("done_timing", 32'(cyc), 32'(last_xfer_cyc + 1));
          check("enable_low_at_done", 32'(o_en), 32'd0);
          if (expect_full_en) check("enable_cycles", 32'(en_cycles), 32'd60);
          run_done = 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int stall_left;
    bit stalled [int];
    build_sbox();

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_enable", 32'(o_en), 32'd0);
    check("rst_key", o_key, 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // FIPS-197 A.3 key, ready always high
    set_a3_key();
    start_run(1'b1);
    load_key(0);
    wait_done(100);
    check("latency_a3", 32'(first_en_cyc - last_key_cyc), 32'd1);
    @(posedge clk); #1;
    check("idle_after_done", 32'(o_state), 32'(IDLE));
    check("busy_after_done", 32'(o_busy), 32'd0);

    // Backpressure at w7, w8, w12
    start_run(1'b0);
    load_key(0);
    stall_left = 0;
    for (int t = 0; t < 200 && !run_done; t++) begin
      @(posedge clk); #1;
      if (ready && o_en && (run_xfer == 7 || run_xfer == 8 || run_xfer == 12) && !stalled.exists(run_xfer)) begin
        stalled[run_xfer] = 1;
        ready = 1'b0;
        stall_left = 3;
      end else if (!ready) begin
        stall_left--;
        if (stall_left == 0) ready = 1'b1;
      end
    end
    ready = 1'b1;
    wait_done(20);
    check("stall_enable_cycles", 32'(en_cycles), 32'd69);

    // Gapped load
    start_run(1'b1);
    load_key(2);
    wait_done(100);
    check("latency_gapped", 32'(first_en_cyc - last_key_cyc), 32'd1);

    // Junk key words during EMIT are dropped
    start_run(1'b1);
    load_key(0);
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      key_en = t[0];
      key_w  = 32'hbad00000 + 32'(t);
    end
    key_en = 1'b0;
    key_w  = '0;
    wait_done(100);
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_junk", 32'(o_state), 32'(IDLE));

    // Reset while w20 is presented
    start_run(1'b1);
    load_key(0);
    for (int t = 0; t < 100 && run_xfer < 20; t++) @(posedge clk);
    #1;
    check("reached_w20", 32'(run_xfer), 32'd20);
    check("presenting_w20", o_key, model_w[20]);
    rst = 1'b0;
    #1;
    check("abort_enable", 32'(o_en), 32'd0);
    check("abort_key", o_key, 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_state", 32'(o_state), 32'(IDLE));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(run_done), 32'd0);
    rst = 1'b1;
    start_run(1'b1);
    load_key(0);
    wait_done(100);

    // All-zero key
    for (int i = 0; i < 8; i++) cur_key[i] = '0;
    anchor.delete();
    anchor[8]  = 32'h62636363;
    anchor[12] = 32'haafbfbfb;
    start_run(1'b1);
    load_key(0);
    wait_done(100);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
